// File: rtl/mult_seq_ctrl_if.sv
// Control interface between the shift-add multiplier sequencer and its
// datapath. The slave modport is the sequencer's view; the master modport is
// the datapath/stimulus side that supplies start and the B operand.
interface mult_seq_ctrl_if #(
  parameter int N      = 6,
  parameter int BSEL_W = 3,
  parameter int CNT_W  = 5
);
  logic              start;
  logic [N-1:0]      b_in;
  logic [1:0]        usr_sel;
  logic              usr_clr;
  logic              acc_ld;
  logic              acc_clr;
  logic [BSEL_W-1:0] bit_sel;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  cycles;

  modport slave (
    input  start, b_in,
    output usr_sel, usr_clr, acc_ld, acc_clr, bit_sel, busy, done, cycles
  );

  modport master (
    output start, b_in,
    input  usr_sel, usr_clr, acc_ld, acc_clr, bit_sel, busy, done, cycles
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the N-bit shift-add multiplier datapath.
// A registered start edge launches LOAD (clear accumulator, load A), then one
// ACCUM cycle per B bit, then DONE holds the product until the next start edge.
// Optional feature macro: EARLY_TERM_EN -- leave ACCUM as soon as all remaining
// B bits are zero (cycles then reports the bits actually consumed).
module mult_seq_ctrl #(
  parameter int N      = 6,
  parameter int BSEL_W = 3,
  parameter int CNT_W  = 5
) (
  input  logic               clk,
  input  logic               clr,
  mult_seq_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    ACCUM = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [BSEL_W-1:0] LAST_I = BSEL_W'(N - 1);

  state_t            state;
  state_t            state_next;
  logic [BSEL_W-1:0] i;
  logic [BSEL_W-1:0] i_next;
  logic [CNT_W-1:0]  cycles;
  logic [CNT_W-1:0]  cycles_next;
  logic              start_q;
  logic              start_rise;
  logic              b_rest_zero;

  logic [1:0]        usr_sel;
  logic              acc_ld;
  logic              acc_clr_st;
  logic              busy;
  logic              done;

`ifdef EARLY_TERM_EN
  assign b_rest_zero = ((bus.b_in >> i) == '0);
`else
  assign b_rest_zero = 1'b0;
`endif

  // Edge detector: a level held high produces only one registered pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      start_q    <= 1'b0;
      start_rise <= 1'b0;
    end else begin
      start_q    <= bus.start;
      start_rise <= bus.start & ~start_q;
    end
  end

  // State, bit index and cycle counter registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      i      <= '0;
      cycles <= '0;
    end else begin
      state  <= state_next;
      i      <= i_next;
      cycles <= cycles_next;
    end
  end

  // Next-state and control decode; start edges outside IDLE/DONE are dropped.
  always_comb begin
    state_next  = state;
    i_next      = i;
    cycles_next = cycles;
    usr_sel     = 2'b00;
    acc_ld      = 1'b0;
    acc_clr_st  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        usr_sel     = 2'b01;
        acc_clr_st  = 1'b1;
        busy        = 1'b1;
        i_next      = '0;
        cycles_next = '0;
        state_next  = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (b_rest_zero) begin
          state_next = DONE;
        end else begin
          acc_ld      = 1'b1;
          usr_sel     = 2'b10;
          cycles_next = cycles + CNT_W'(1);
          if (i == LAST_I) begin
            state_next = DONE;
          end else begin
            i_next = i + BSEL_W'(1);
          end
        end
      end
      DONE: begin
        done = 1'b1;
        if (start_rise) begin
          state_next = LOAD;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath clears follow clr directly so the datapath resets with us.
  assign bus.usr_clr = clr;
  assign bus.acc_clr = acc_clr_st | clr;
  assign bus.usr_sel = usr_sel;
  assign bus.acc_ld  = acc_ld;
  assign bus.bit_sel = i;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.cycles  = cycles;

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequencer for the 6-bit shift-add multiplier datapath. The datapath is a 12-bit universal shift register holding A, a bit-select mux over B, a 2:1 gate, a ripple-carry adder, and an accumulator register.
- Detects a start edge.
- Clears the accumulator and loads A.
- Steps the B-bit select while commanding the shift register and accumulator for N cycles.
- Holds the result with a done flag until the next start.
- Replaces the generic button FSM; runs on the divided slow clock.

Parameters:
N, 6, multiplier operand width (iterations per multiply); legal 2..16
BSEL_W, 3, width of bit_sel; must satisfy 2**BSEL_W >= N
CNT_W, 5, width of cycles counter; must hold N+1

Ports:
clk  input  1  slow system clock (divider output); all state on rising edge
clr  input  1  asynchronous active-high reset
start  input  1  start request (button level); rising edge starts a multiply
b_in  input  N  multiplier operand B; must be stable while busy=1
usr_sel  output  2  shift-register mode: 00 hold, 01 parallel load, 10 shift left, 11 unused (never driven)
usr_clr  output  1  shift-register clear
acc_ld  output  1  accumulator load enable
acc_clr  output  1  accumulator clear
bit_sel  output  BSEL_W  B bit-select mux control (index of current B bit)
busy  output  1  multiply in progress (LOAD or ACCUM)
done  output  1  accumulator holds a valid product
cycles  output  CNT_W  ACCUM cycles used by the last or current multiply

Behaviour:
- Start detect: start_q <= start each clk.
  - start_rise = start & ~start_q, registered in the controller.
  - Level held high never retriggers.
- States: IDLE, LOAD, ACCUM, DONE; state register, bit index i (BSEL_W bits), cycles counter.
- Reset (clr=1, async):
  - State = IDLE, i = 0, cycles = 0, start_q = 0.
  - usr_sel = 00, acc_ld = 0, bit_sel = 0, busy = 0, done = 0.
  - usr_clr = acc_clr = 1 while clr is high (combinational OR with clr) so the datapath is cleared with the controller.
  - Reset mid-operation aborts immediately; no partial result flagged.
- IDLE: all controls inactive. start_rise -> LOAD.
- LOAD (1 cycle):
  - usr_sel = 01 (loads zero-extended A), acc_clr = 1, busy = 1, done = 0.
  - i <= 0, cycles <= 0. Next state ACCUM.
- ACCUM (one cycle per bit):
  - bit_sel = i, acc_ld = 1, usr_sel = 10, busy = 1.
  - The accumulator captures acc + (b_in[i] ? C : 0) on the same edge that the shift register doubles C.
  - cycles <= cycles + 1.
  - If i == N-1 -> DONE; else i <= i + 1.
- DONE:
  - done = 1, busy = 0, usr_sel = 00, acc_ld = 0, bit_sel holds the last i.
  - The product stays stable in the accumulator.
  - start_rise -> LOAD (done drops the next cycle).
- Latency: start_rise registered at edge k; LOAD during cycle k+1; ACCUM during cycles k+2 .. k+N+1; done=1 from cycle k+N+2. Default N=6: 8 cycles after start edge detection.
- start_rise during LOAD or ACCUM: ignored; no restart, no queueing.
- start and clr together: clr wins.
- Width rule: the datapath product is 2N bits. The controller issues exactly N shifts, so A is never shifted past bit 2N-1.
- bit_sel never exceeds N-1.

Optional Feature:
Macro EARLY_TERM_EN.
- Defined: in ACCUM, if (b_in >> i) == 0 (all remaining B bits zero):
  - That cycle drives acc_ld = 0, usr_sel = 00.
  - cycles is not incremented.
  - Next state DONE.
  - For B=0, done asserts the cycle after ACCUM is entered; cycles reports the bits actually used.
- Undefined: always N ACCUM cycles; cycles = N at DONE; the b_in comparison logic is absent.

Test Plan:
- Reset, then start pulse with A=5, B=6 -> busy for 7 cycles; done=1 at cycle 8 after edge detection; product = 30; cycles = 6; bit_sel steps 0..5 during ACCUM.
- A=63, B=63 -> product 3969 (0xF81), no overflow; then hold start high for 20 cycles -> exactly one multiply, done stays 1.
- Back-to-back: A=7, B=9 -> 63, done; new start edge with B=2 -> done drops the next cycle; LOAD clears the accumulator; product = 14 (no residue from 63).
- Start edge mid-ACCUM (third ACCUM cycle) -> ignored; done timing and product unchanged.
- Assert clr during the fourth ACCUM cycle -> immediate IDLE; usr_clr = acc_clr = 1 while clr high; busy = done = 0; next start gives a correct product.
- EARLY_TERM_EN defined, B=0 -> done 1 cycle after LOAD, product 0, cycles 0. B=3 (0b000011) -> cycles 2, product 3*A. Macro undefined, same stimulus -> cycles 6, same products.
